riscv_retire_monitor: RTL

//   Core-side producer of the architectural status the lab benches check: NUM_INST, OUTPUT_PORT, HALT.

---
 rtl/riscv_retire_monitor.sv | 100 ++++++++++
 1 files changed

// File: rtl/riscv_retire_monitor.sv
// ============================================================================
// riscv_retire_monitor
//   Counts retired instructions, latches each retiree's observable result and
//   detects the two-word halt sequence (HALT sticky until reset).
//   Revision: 1.0
// ============================================================================
`default_nettype none

module riscv_retire_monitor #(
    parameter int          CNT_W      = 32,
    parameter logic [31:0] HALT_INST0 = 32'h00c00093,
    parameter logic [31:0] HALT_INST1 = 32'h00008067
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        RET_VALID,
    input  logic        RET_KILL,
    input  logic [31:0] RET_INST,
    input  logic [31:0] RET_PC,
    input  logic        RET_RF_WE,
    input  logic [31:0] RET_RF_WD,
    input  logic [31:0] RET_MEM_ADDR,
    input  logic        RET_BR_TAKEN,
    output logic [31:0] NUM_INST,
    output logic [31:0] OUTPUT_PORT,
    output logic        HALT
);

    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEEN0 = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [31:0]      result;
    logic             halt;
    logic             retire;
    logic             unused_pc;

    // The PC travels with the record for trace only.
    assign unused_pc = ^RET_PC;

    assign retire = RET_VALID & ~RET_KILL & ~halt;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state  <= IDLE;
            count  <= '0;
            result <= 32'd0;
            halt   <= 1'b0;
        end else if (retire) begin
            if (count != {CNT_W{1'b1}})
                count <= count + 1'b1;

            if (RET_INST[6:0] == OP_STORE)
                result <= RET_MEM_ADDR;
            else if (RET_INST[6:0] == OP_BRANCH)
                result <= {31'd0, RET_BR_TAKEN};
            else if (RET_RF_WE)
                result <= RET_RF_WD;

            case (state)
                IDLE: begin
                    if (RET_INST == HALT_INST0)
                        state <= SEEN0;
                end
                SEEN0: begin
                    if (RET_INST == HALT_INST1) begin
                        state <= DONE;
                        halt  <= 1'b1;
                    end else if (RET_INST != HALT_INST0) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

    generate
        if (CNT_W >= 32) begin : g_full
            assign NUM_INST = count[31:0];
        end else begin : g_ext
            assign NUM_INST = {{(32-CNT_W){1'b0}}, count};
        end
    endgenerate

    assign OUTPUT_PORT = result;
    assign HALT        = halt;

endmodule

`default_nettype wire
